// File: rtl/vip_adaptive.sv
// vip_adaptive: RGB pixel stream to luminance, with four selectable outputs
// (bypass, gray, binary, inverted binary). 3-stage pipeline, one pixel per clk.
// The binarisation threshold is either the manual value or the midpoint of the
// previous frame's min/max luminance. Mode and threshold are shadowed on the
// frame boundary (rising edge of stage-2 vsync), so a frame never mixes settings.
//
// Ports:
//   clk, rst              pixel clock, asynchronous active-high reset
//   mode[1:0]             0 bypass, 1 gray, 2 binary, 3 inverted binary
//   auto_en               1 = automatic threshold, 0 = manual `threshold`
//   threshold[7:0]        manual luminance threshold
//   pre_frame_vsync/hsync/de, pre_rgb[PW-1:0]    input stream, {R,G,B} MSB first
//   post_frame_vsync/hsync/de, post_rgb[PW-1:0]  output stream, 3 cycles later
//   auto_thr[7:0]         current automatic threshold
//   frame_thr[7:0]        threshold in force for the current frame
//   frame_mode[1:0]       mode in force for the current frame
module vip_adaptive #(
    parameter int unsigned RW = 5,
    parameter int unsigned GW = 6,
    parameter int unsigned BW = 5,
    localparam int unsigned PW = RW + GW + BW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    mode,
    input  logic          auto_en,
    input  logic [7:0]    threshold,
    input  logic          pre_frame_vsync,
    input  logic          pre_frame_hsync,
    input  logic          pre_frame_de,
    input  logic [PW-1:0] pre_rgb,
    output logic          post_frame_vsync,
    output logic          post_frame_hsync,
    output logic          post_frame_de,
    output logic [PW-1:0] post_rgb,
    output logic [7:0]    auto_thr,
    output logic [7:0]    frame_thr,
    output logic [1:0]    frame_mode
);

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_GRAY   = 2'd1;
    localparam logic [1:0] MODE_BIN    = 2'd2;

    localparam logic [7:0] THR_RESET = 8'd128;

    // Expand a w-bit channel (held in the low bits of c) to 8 bits by
    // repeating its MSBs below it; identity for w = 8.
    function automatic logic [7:0] expand8(input logic [7:0] c, input int unsigned w);
        logic [7:0] e;
        e = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            e[3'(7 - i)] = c[3'(w - 1 - (i % w))];
        end
        return e;
    endfunction

    // Channel split and expansion of the incoming pixel
    logic [7:0] r8, g8, b8;
    always_comb begin
        r8 = expand8(8'(pre_rgb[PW-1 -: RW]), RW);
        g8 = expand8(8'(pre_rgb[GW+BW-1 -: GW]), GW);
        b8 = expand8(8'(pre_rgb[BW-1:0]), BW);
    end

    // Stage 1: weighted channel products, raw pixel and syncs
    logic [15:0]   pr1, pg1, pb1;
    logic [PW-1:0] raw1;
    logic          vs1, hs1, de1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pr1  <= '0;
            pg1  <= '0;
            pb1  <= '0;
            raw1 <= '0;
            vs1  <= 1'b0;
            hs1  <= 1'b0;
            de1  <= 1'b0;
        end else begin
            pr1  <= 16'(r8) * 16'd77;
            pg1  <= 16'(g8) * 16'd150;
            pb1  <= 16'(b8) * 16'd29;
            raw1 <= pre_rgb;
            vs1  <= pre_frame_vsync;
            hs1  <= pre_frame_hsync;
            de1  <= pre_frame_de;
        end
    end

    // Stage 2: luminance. Weights sum to 256, so the sum never exceeds 65280.
    logic [16:0]   sum_c;
    logic [7:0]    y2;
    logic [PW-1:0] raw2;
    logic          vs2, hs2, de2, vs2_q;

    assign sum_c = 17'(pr1) + 17'(pg1) + 17'(pb1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y2    <= '0;
            raw2  <= '0;
            vs2   <= 1'b0;
            hs2   <= 1'b0;
            de2   <= 1'b0;
            vs2_q <= 1'b0;
        end else begin
            y2    <= 8'(sum_c >> 8);
            raw2  <= raw1;
            vs2   <= vs1;
            hs2   <= hs1;
            de2   <= de1;
            vs2_q <= vs2;
        end
    end

    // Frame boundary: rising edge of stage-2 vsync
    logic boundary;
    assign boundary = vs2 & ~vs2_q;

    // Per-frame luminance statistics
    logic [7:0] min_y, max_y;
    logic       seen;

    // Settings for the pixel now in stage 2. In the boundary cycle the freshly
    // shadowed values are used, so the output word aligned with the output
    // vsync rise already belongs to the new frame.
    logic [7:0]    auto_nxt;
    logic [1:0]    mode_eff;
    logic [7:0]    thr_eff;
    logic [PW-1:0] gray_c;
    logic          hit;
    logic [PW-1:0] pix_nxt;

    always_comb begin
        auto_nxt = auto_thr;
        if (seen) begin
            auto_nxt = 8'((9'(min_y) + 9'(max_y)) >> 1);
        end

        mode_eff = frame_mode;
        thr_eff  = frame_thr;
        if (boundary) begin
            mode_eff = mode;
            thr_eff  = auto_en ? auto_nxt : threshold;
        end

        gray_c = {y2[7 -: RW], y2[7 -: GW], y2[7 -: BW]};
        hit    = (y2 >= thr_eff);

        case (mode_eff)
            MODE_BYPASS: pix_nxt = raw2;
            MODE_GRAY:   pix_nxt = gray_c;
            MODE_BIN:    pix_nxt = {PW{hit}};
            default:     pix_nxt = {PW{~hit}};
        endcase
    end

    // Statistics and shadow registers; a de pixel in the boundary cycle is ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_y      <= 8'd255;
            max_y      <= 8'd0;
            seen       <= 1'b0;
            auto_thr   <= THR_RESET;
            frame_thr  <= THR_RESET;
            frame_mode <= MODE_BYPASS;
        end else if (boundary) begin
            auto_thr   <= auto_nxt;
            min_y      <= 8'd255;
            max_y      <= 8'd0;
            seen       <= 1'b0;
            frame_mode <= mode;
            frame_thr  <= auto_en ? auto_nxt : threshold;
        end else if (de2) begin
            if (y2 < min_y) begin
                min_y <= y2;
            end
            if (y2 > max_y) begin
                max_y <= y2;
            end
            seen <= 1'b1;
        end
    end

    // Stage 3: output selection and sync alignment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            post_rgb         <= '0;
            post_frame_vsync <= 1'b0;
            post_frame_hsync <= 1'b0;
            post_frame_de    <= 1'b0;
        end else begin
            post_rgb         <= pix_nxt;
            post_frame_vsync <= vs2;
            post_frame_hsync <= hs2;
            post_frame_de    <= de2;
        end
    end

endmodule

// File: doc/vip_adaptive.md
# vip_adaptive

Parametrised successor to the fixed RGB565 gray/binary image path. It is a single 3-stage pipeline that converts an RGB pixel stream to luminance and emits one of four selectable outputs: bypass, grayscale, binary, or inverted binary. The binarisation threshold is either the software-supplied value or an automatic per-frame value, computed as the midpoint of the previous frame's min/max luminance. Mode and threshold change only on frame boundaries, so no frame is ever rendered with mixed settings. It sits between the camera/frame-buffer read path and the LCD driver, with control fields driven from an APB register block.

## Interface
Parameters:
- RW, default 5: red channel width (legal 4..8)
- GW, default 6: green channel width (legal 4..8)
- BW, default 5: blue channel width (legal 4..8)
- PW, derived RW+GW+BW: pixel width, same for input and output

Ports:
- clk  in  1  pixel clock; the only clock
- rst  in  1  asynchronous, active-high reset
- mode  in  2  0 bypass, 1 gray, 2 binary, 3 inverted binary
- auto_en  in  1  1 = use automatic threshold, 0 = use `threshold`
- threshold  in  8  manual luminance threshold
- pre_frame_vsync  in  1  frame sync, active high
- pre_frame_hsync  in  1  line sync
- pre_frame_de  in  1  pixel valid
- pre_rgb  in  PW  pixel packed {R,G,B}, MSB first
- post_frame_vsync  out  1  vsync delayed 3
- post_frame_hsync  out  1  hsync delayed 3
- post_frame_de  out  1  de delayed 3
- post_rgb  out  PW  processed pixel
- auto_thr  out  8  current automatic threshold
- frame_thr  out  8  threshold in force for the current frame
- frame_mode  out  2  mode in force for the current frame

## Operation
- Channel expansion to 8 bits is done by MSB replication: c8 = {c, c[W-1 -: 8-W]} when W<8, and identity when W=8.
- Stage 1 registers the products 77·R8, 150·G8 and 29·B8, the raw pixel, and the syncs.
- Stage 2 registers Y = (sum) >> 8. The sum is held in 17 bits; Y is 8 bits unsigned, with 255 as its maximum.
- Stage 3 registers the output selected by the shadowed mode:
  - bypass: the raw pixel, delayed.
  - gray: {Y[7 -: RW], Y[7 -: GW], Y[7 -: BW]}.
  - binary: all ones if Y >= frame_thr, else all zeros.
  - inverted binary: the complement of binary.
- Outputs outside de follow the same path; there is no forced blanking.
- Frame boundary is the rising edge of stage-2 vsync (vs2 & ~vs2_q).
- Statistics are collected on stage-2 data while de2 = 1: min_y, max_y, and a seen flag.
- On a frame boundary, all of the following happen in the same cycle:
  - If seen is set, auto_thr <= (min_y + max_y) >> 1 using a 9-bit sum; if seen is clear, auto_thr holds its value.
  - min_y <= 255, max_y <= 0, seen <= 0.
  - frame_mode <= mode.
  - frame_thr <= auto_en ? (new auto_thr value) : threshold.
  - The new auto_thr applies to the frame that is just starting.
- A pixel with de2 in the boundary cycle cannot occur legally; if it does, it is ignored for statistics.
- Mode, threshold and auto_en changes mid-frame have no effect until the next boundary.

## Timing
- Latency is exactly 3 clk cycles from input to output for pixel data and syncs, in every mode.
- Throughput is one pixel per clk. There is no stall and no backpressure.
- Reset values:
  - post_* and all pipeline registers: 0
  - auto_thr: 128
  - frame_thr: 128
  - frame_mode: 0
  - min_y: 255, max_y: 0, seen: 0
- Reset asserted mid-frame clears state immediately. The first boundary after release uses the reset statistics (seen = 0), so auto_thr stays at 128.
- Shadow registers update in the boundary cycle. The first stage-3 output using them appears 1 cycle later, aligned with the vsync rising edge on the output.

## Test plan
- Gray, RGB565: pre_rgb 16'hFFFF -> post_rgb 16'hFFFF three cycles later. 16'hF800 (Y = 76) -> 16'h4A69.
- Binary, manual, threshold 100, boundary applied: 16'hF800 -> 16'h0000 and 16'hFFFF -> 16'hFFFF. Mode 3 with the same inputs -> 16'hFFFF and 16'h0000.
- Auto threshold: a frame containing only Y = 76 and Y = 255 pixels, auto_en = 1 -> after the next vsync rise, auto_thr = 165 and frame_thr = 165. In the following frame, Y = 160 -> 0.
- Frame with no de pixels -> auto_thr is unchanged across the boundary. Changing mode from 1 to 2 mid-frame -> output stays gray until the next vsync, then becomes binary.
- Parameters RW = GW = BW = 8: pixel 24'hFFFFFF -> gray 24'hFFFFFF. Bypass of 24'h123456 -> 24'h123456 after 3 cycles, with de/hsync/vsync also delayed by 3.
- Assert rst mid-line -> all outputs 0 asynchronously and auto_thr = 128. Stream resumes with correct 3-cycle latency.
